// File: rtl/counter_pkg.sv
// counter_pkg: shared constants for the modulo counter family.
//   DIR_UP / DIR_DOWN     : encoding of the dir input
//   MODE_WRAP / MODE_ONESHOT : encoding of the oneshot input
//   DEF_WIDTH / DEF_PW    : default counter and prescaler widths
package counter_pkg;

    localparam logic DIR_UP       = 1'b1;
    localparam logic DIR_DOWN     = 1'b0;

    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_PW    = 4;

endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler: divides enabled cycles down to a single-cycle tick.
// Ports:
//   clk  in  : clock, rising edge
//   rst  in  : synchronous active-low reset, clears the divider
//   en   in  : advance the divider; 0 freezes it
//   clr  in  : synchronous clear of the divider (used on counter load)
//   div  in  : tick every div+1 enabled cycles
//   tick out : combinational from the pc flop, qualified by en
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PW = DEF_PW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic [PW-1:0] div,
    output logic          tick
);

    logic [PW-1:0] pc;

    assign tick = en && (pc == div);

    // If div is lowered below the current pc, pc runs on and wraps
    // naturally before matching again.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc <= '0;
        end else if (clr) begin
            pc <= '0;
        end else if (en) begin
            if (tick) pc <= '0;
            else      pc <= pc + PW'(1);
        end
    end

endmodule

// File: rtl/mod_counter.sv
// mod_counter: loadable up/down modulo counter with prescaler, terminal
// count pulse, one-shot mode and sticky overflow flag.
// Ports:
//   clk, rst   : clock (rising edge), synchronous active-low reset
//   en         : count enable (gates prescaler and counter)
//   load       : load load_val into cnt, clears prescaler, done and tc
//   load_val   : value to load
//   max_val    : terminal value, sampled every cycle
//   dir        : 1 up, 0 down
//   oneshot    : 1 stop at terminal, 0 wrap
//   presc_div  : tick every presc_div+1 enabled cycles
//   ovf_clr    : clear ovf (a coincident set wins)
//   cnt        : current count
//   tc         : registered one-cycle terminal-count pulse
//   done       : one-shot terminal reached (level, cleared by load/reset)
//   ovf        : sticky missed-service flag
// Priority: reset > load > tick > hold. All outputs are flops.
module mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PW    = DEF_PW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic             dir,
    input  logic             oneshot,
    input  logic [PW-1:0]    presc_div,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             done,
    output logic             ovf
);

    logic tick;

    counter_prescaler #(.PW(PW)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .div  (presc_div),
        .tick (tick)
    );

    logic             at_term;
    logic             frozen;
    logic             wrap_evt;
    logic [WIDTH-1:0] cnt_step;
    logic [WIDTH-1:0] cnt_wrap;

    // Terminal compare uses the current direction; a loaded value beyond
    // max_val simply never matches until it rolls over naturally.
    always_comb begin
        at_term  = (dir == DIR_UP) ? (cnt == max_val) : (cnt == '0);
        cnt_step = (dir == DIR_UP) ? (cnt + WIDTH'(1)) : (cnt - WIDTH'(1));
        cnt_wrap = (dir == DIR_UP) ? '0 : max_val;
        // A finished one-shot ignores ticks; dropping oneshot releases it.
        frozen   = done && (oneshot == MODE_ONESHOT);
        wrap_evt = tick && !load && !frozen && at_term && (oneshot == MODE_WRAP);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            tc   <= 1'b0;
            done <= 1'b0;
        end else if (load) begin
            cnt  <= load_val;
            tc   <= 1'b0;
            done <= 1'b0;
        end else if (tick && !frozen) begin
            if (at_term) begin
                tc <= 1'b1;
                if (oneshot == MODE_ONESHOT) begin
                    done <= 1'b1;
                end else begin
                    cnt <= cnt_wrap;
                end
            end else begin
                cnt <= cnt_step;
                tc  <= 1'b0;
            end
        end else begin
            tc <= 1'b0;
        end
    end

    // ovf flags a wrap event arriving while the previous tc is still
    // visible, i.e. software never got a cycle to service it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (wrap_evt && tc) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// Directed scenarios followed by randomized traffic, every cycle compared
// against a behavioural model of the counter's rules.
module tb_mod_counter;

    localparam int WIDTH = 8;
    localparam int PW    = 4;
    localparam int MODV  = 1 << WIDTH;
    localparam int PMODV = 1 << PW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] max_val;
    logic             dir;
    logic             oneshot;
    logic [PW-1:0]    presc_div;
    logic             ovf_clr;
    logic [WIDTH-1:0] cnt;
    logic             tc;
    logic             done;
    logic             ovf;

    mod_counter #(.WIDTH(WIDTH), .PW(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .load_val  (load_val),
        .max_val   (max_val),
        .dir       (dir),
        .oneshot   (oneshot),
        .presc_div (presc_div),
        .ovf_clr   (ovf_clr),
        .cnt       (cnt),
        .tc        (tc),
        .done      (done),
        .ovf       (ovf)
    );

    // ---------------- reference model ----------------
    int m_cnt, m_pc;
    bit m_tc, m_done, m_ovf;
    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    // Next state from the current inputs, following the counter's rules.
    task automatic model_step();
        bit t, term, was_tc;
        int n_cnt, n_pc;
        bit n_tc, n_done, n_ovf;
        was_tc = m_tc;
        if (!rst) begin
            n_cnt = 0; n_pc = 0; n_tc = 0; n_done = 0; n_ovf = 0;
        end else begin
            t      = en && (m_pc == int'(presc_div));
            n_pc   = load ? 0 : (en ? (t ? 0 : (m_pc + 1) % PMODV) : m_pc);
            n_cnt  = m_cnt; n_tc = 0; n_done = m_done; n_ovf = m_ovf;
            if (ovf_clr) n_ovf = 0;
            if (load) begin
                n_cnt = int'(load_val); n_done = 0;
            end else if (t && !(m_done && oneshot)) begin
                term = dir ? (m_cnt == int'(max_val)) : (m_cnt == 0);
                if (term && oneshot) begin
                    n_done = 1; n_tc = !m_done;
                end else if (term) begin
                    n_cnt = dir ? 0 : int'(max_val);
                    n_tc  = 1;
                    if (was_tc) n_ovf = 1;
                end else begin
                    n_cnt = dir ? (m_cnt + 1) % MODV : (m_cnt + MODV - 1) % MODV;
                end
            end
        end
        m_cnt = n_cnt; m_pc = n_pc; m_tc = n_tc; m_done = n_done; m_ovf = n_ovf;
    endtask

    // ---------------- driver: one clock, then scoreboard ----------------
    task automatic do_cycle();
        logic [WIDTH-1:0] e;
        model_step();
        exp_q.push_back(WIDTH'(m_cnt));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        assert (cnt === e) else begin
            errors++; $error("FAIL cnt: got %0d expected %0d", cnt, e);
        end
        checks++;
        assert (tc === m_tc) else begin
            errors++; $error("FAIL tc: got %b expected %b (cnt=%0d)", tc, m_tc, cnt);
        end
        checks++;
        assert (done === m_done) else begin
            errors++; $error("FAIL done: got %b expected %b", done, m_done);
        end
        checks++;
        assert (ovf === m_ovf) else begin
            errors++; $error("FAIL ovf: got %b expected %b", ovf, m_ovf);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) do_cycle();
    endtask

    task automatic check_const(input string tag, input int got, input int want);
        checks++;
        assert (got == want) else begin
            errors++; $error("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic do_load(input int v);
        load = 1'b1; load_val = WIDTH'(v);
        do_cycle();
        load = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        m_cnt = 0; m_pc = 0; m_tc = 0; m_done = 0; m_ovf = 0;
        rst = 1'b0; en = 1'b1; load = 1'b0; load_val = '0; max_val = 8'd255;
        dir = 1'b1; oneshot = 1'b0; presc_div = '0; ovf_clr = 1'b0;

        // Reset held two cycles with en high
        run(2);
        check_const("reset_cnt", int'(cnt), 0);
        check_const("reset_flags", int'({tc, done, ovf}), 0);
        rst = 1'b1;
        run(1);
        check_const("first_count", int'(cnt), 1);

        // Wrap up, max 5: 0..5,0 with tc on the wrap
        max_val = 8'd5;
        do_load(0);
        run(5);
        check_const("wrap_top", int'(cnt), 5);
        run(1);
        check_const("wrap_zero", int'(cnt), 0);
        check_const("wrap_tc", int'(tc), 1);
        run(7);

        // Prescaled down wrap, max 3, div 2
        dir = 1'b0; max_val = 8'd3; presc_div = 4'd2;
        do_load(3);
        run(14);

        // One-shot from 250 to 252
        dir = 1'b1; oneshot = 1'b1; max_val = 8'd252; presc_div = 4'd0;
        do_load(250);
        run(6);
        check_const("oneshot_hold", int'(cnt), 252);
        check_const("oneshot_done", int'(done), 1);
        do_load(0);
        check_const("oneshot_clear", int'(done), 0);
        run(2);

        // Load priority over a coincident tick
        oneshot = 1'b0; max_val = 8'd255;
        do_load(8'h40);
        check_const("load_prio", int'(cnt), 8'h40);

        // max 0, back-to-back terminal events: tc stays high, ovf sets
        max_val = 8'd0;
        do_load(0);
        run(3);
        check_const("ovf_set", int'(ovf), 1);
        ovf_clr = 1'b1;
        run(2);
        check_const("ovf_set_wins", int'(ovf), 1);
        en = 1'b0;
        run(1);
        check_const("ovf_cleared", int'(ovf), 0);
        ovf_clr = 1'b0; en = 1'b1;

        // Beyond-terminal load: 254,255,0 quietly then 1..10,0 with tc
        max_val = 8'd10;
        do_load(254);
        run(2);
        check_const("beyond_roll_tc", int'(tc), 0);
        run(11);
        check_const("beyond_wrap_tc", int'(tc), 1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rst       = ($urandom_range(0, 79) != 0);
            load      = ($urandom_range(0, 24) == 0);
            load_val  = WIDTH'($urandom_range(0, 255));
            en        = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) dir = 1'($urandom);
            if ($urandom_range(0, 31) == 0) oneshot = 1'($urandom);
            if ($urandom_range(0, 15) == 0) max_val = WIDTH'($urandom_range(0, 12));
            if ($urandom_range(0, 31) == 0) presc_div = PW'($urandom_range(0, 3));
            do_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
